core_run_ctrl: RTL and testbench

//  Parametrised run controller for the pipelined core under simulation/FPGA bring-up.

---
 rtl/core_run_ctrl.sv | 136 +++++++++++++
 tb/tb_core_run_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, counts cycles/retires, detects halt and timeout.
// Optional stall counting and stall-masked halt detection enabled by defining STALL_CNT_EN.
module core_run_ctrl #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int RST_HOLD   = 4,
    parameter int HALT_WIN   = 3,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_clr,
    input  logic             run_en,
    input  logic [PC_W-1:0]  pc,
    input  logic             retire,
    input  logic             stall,
    output logic             core_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_RESET   = 2'b00,
        S_RUN     = 2'b01,
        S_HALT    = 2'b10,
        S_TIMEOUT = 2'b11
    } state_t;

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int SW = $clog2(HALT_WIN + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0]    SAME_LAST = SW'(HALT_WIN - 2);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [HW-1:0]     hold_ctr;
    logic [SW-1:0]     same_ctr;
    logic [PC_W-1:0]   prev_pc;
    logic              prev_valid;
    logic              stall_eff;
    logic              count_en;
    logic              same_match;
    logic              halt_hit;
    logic              timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic b);
        return (b && (a != '1)) ? a + CNT_W'(1) : a;
    endfunction

`ifdef STALL_CNT_EN
    assign stall_eff = stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (soft_clr)
            stall_cnt <= '0;
        else if (count_en)
            stall_cnt <= sat_inc(stall_cnt, stall);
    end
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_eff    = 1'b0;
    assign stall_cnt    = '0;
`endif

    assign count_en    = (cur_state == S_RUN) && run_en;
    assign same_match  = prev_valid && (pc == prev_pc);
    assign halt_hit    = count_en && !stall_eff && same_match && (same_ctr == SAME_LAST);
    assign timeout_hit = count_en && (cycle_cnt == CYC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cur_state <= S_RESET;
        else
            cur_state <= nxt_state;
    end

    // soft_clr outranks everything; halt outranks timeout on the same cycle
    always_comb begin
        nxt_state = cur_state;
        if (soft_clr) begin
            nxt_state = S_RESET;
        end else begin
            case (cur_state)
                S_RESET: if (hold_ctr == HOLD_LAST) nxt_state = S_RUN;
                S_RUN: begin
                    if (halt_hit)
                        nxt_state = S_HALT;
                    else if (timeout_hit)
                        nxt_state = S_TIMEOUT;
                end
                default: nxt_state = cur_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || soft_clr) begin
            hold_ctr   <= '0;
            same_ctr   <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (cur_state == S_RESET)
                hold_ctr <= hold_ctr + HW'(1);
            if (count_en) begin
                cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
                retire_cnt <= sat_inc(retire_cnt, retire);
                prev_pc    <= pc;
                prev_valid <= 1'b1;
                // stalled cycles leave the halt window untouched
                if (!stall_eff) begin
                    if (same_match)
                        same_ctr <= same_ctr + SW'(1);
                    else if (pc != prev_pc)
                        same_ctr <= '0;
                end
            end
        end
    end

    assign state    = cur_state;
    assign core_rst = (cur_state == S_RESET);
    assign done     = cur_state[1];
    assign timeout  = (cur_state == S_TIMEOUT);

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: stimulus pushes model expectations, monitor pops and compares.
// Works in both builds; STALL_CNT_EN selects the matching reference behaviour.
module tb_core_run_ctrl;

    localparam int PC_W       = 32;
    localparam int CNT_W      = 32;
    localparam int RST_HOLD   = 4;
    localparam int HALT_WIN   = 3;
    localparam int MAX_CYCLES = 20;

    logic             clk;
    logic             rst;
    logic             soft_clr;
    logic             run_en;
    logic [PC_W-1:0]  pc;
    logic             retire;
    logic             stall;
    logic             core_rst;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             done;
    logic             timeout;

    core_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD),
        .HALT_WIN(HALT_WIN), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .soft_clr(soft_clr), .run_en(run_en), .pc(pc),
        .retire(retire), .stall(stall), .core_rst(core_rst), .state(state),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
        .done(done), .timeout(timeout)
    );

    typedef struct {
        logic [1:0]  st;
        logic        crst;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] stl;
        logic        dn;
        logic        to;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    // Reference model: mode 0 reset, 1 run, 2 halt, 3 timeout
    int          mMode;
    int          mHold;
    longint      mCyc;
    longint      mRet;
    longint      mStl;
    logic [31:0] mLastPc;
    bit          mSeenPc;
    int          mRepeats;
    localparam longint SAT = (64'd1 << CNT_W) - 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelClear();
        mMode = 0; mHold = 0; mCyc = 0; mRet = 0; mStl = 0;
        mLastPc = '0; mSeenPc = 0; mRepeats = 0;
    endtask

    // One clock edge of the specified run-controller rules
    task automatic modelEdge(input bit r, input bit sc, input bit en, input logic [31:0] p,
                             input bit rt, input bit sl);
        bit stallCounts;
        bit haltNow;
        bit budgetGone;
`ifdef STALL_CNT_EN
        stallCounts = 1;
`else
        stallCounts = 0;
`endif
        if (!r || sc) begin
            modelClear();
        end else if (mMode == 0) begin
            if (mHold == RST_HOLD - 1) mMode = 1;
            mHold++;
        end else if (mMode == 1 && en) begin
            budgetGone = (mCyc == MAX_CYCLES - 1);
            haltNow = 0;
            if (!(stallCounts && sl)) begin
                if (mSeenPc && p == mLastPc) begin
                    mRepeats++;
                    haltNow = (mRepeats == HALT_WIN - 1);
                end else if (p != mLastPc) begin
                    mRepeats = 0;
                end
            end
            mCyc = (mCyc < SAT) ? mCyc + 1 : mCyc;
            if (rt && mRet < SAT) mRet++;
            if (stallCounts && sl && mStl < SAT) mStl++;
            mLastPc = p;
            mSeenPc = 1;
            if (haltNow) mMode = 2;
            else if (budgetGone) mMode = 3;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit sc, input bit en, input logic [31:0] p,
                                 input bit rt, input bit sl);
        exp_t e;
        @(negedge clk);
        rst = r; soft_clr = sc; run_en = en; pc = p; retire = rt; stall = sl;
        modelEdge(r, sc, en, p, rt, sl);
        e.st   = 2'(mMode);
        e.crst = (mMode == 0);
        e.cyc  = 32'(mCyc);
        e.ret  = 32'(mRet);
        e.stl  = 32'(mStl);
        e.dn   = (mMode >= 2);
        e.to   = (mMode == 3);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so sample a little after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("state",      32'(state),   32'(e.st));
                checkOutput("core_rst",   32'(core_rst), 32'(e.crst));
                checkOutput("cycle_cnt",  cycle_cnt,    e.cyc);
                checkOutput("retire_cnt", retire_cnt,   e.ret);
                checkOutput("stall_cnt",  stall_cnt,    e.stl);
                checkOutput("done",       32'(done),    32'(e.dn));
                checkOutput("timeout",    32'(timeout), 32'(e.to));
            end
        end
    end

    initial begin
        logic [31:0] p;
        rst = 1'b0; soft_clr = 1'b0; run_en = 1'b0; pc = '0; retire = 1'b0; stall = 1'b0;
        modelClear();
        $display("[TB] start");

        // reset held low, then released: RST_HOLD edges of core_rst
        repeat (2) applyStimulus(0, 0, 1, 32'h0, 0, 0);
        for (int i = 0; i < RST_HOLD; i++) applyStimulus(1, 0, 1, 32'h0, 0, 0);

        // 10 retiring cycles with advancing pc
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 32'h100 + 32'(4 * i), 1, 0);

        // branch-to-self at 0x20 declares halt; further activity is frozen
        repeat (3) applyStimulus(1, 0, 1, 32'h20, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 32'h200 + 32'(4 * i), 1, 1);

        // soft_clr out of halt, then run into the cycle budget
        applyStimulus(1, 1, 1, 32'h0, 0, 0);
        for (int i = 0; i < RST_HOLD + MAX_CYCLES + 4; i++)
            applyStimulus(1, 0, 1, 32'h300 + 32'(4 * i), 1'($urandom_range(0, 1)), 0);

        // stalls on a fixed pc: counted, and masking halt when the feature is built
        applyStimulus(1, 1, 0, 32'h0, 0, 0);
        for (int i = 0; i < RST_HOLD; i++) applyStimulus(1, 0, 0, 32'h0, 0, 0);
        repeat (5) applyStimulus(1, 0, 1, 32'h40, 0, 1);
        repeat (4) applyStimulus(1, 0, 1, 32'h40, 0, 0);

        // async reset pulsed in the middle of a run
        applyStimulus(1, 1, 0, 32'h0, 0, 0);
        for (int i = 0; i < RST_HOLD + 5; i++) applyStimulus(1, 0, 1, 32'h500 + 32'(4 * i), 1, 0);
        applyStimulus(0, 0, 1, 32'h0, 1, 0);
        applyStimulus(1, 0, 1, 32'h0, 1, 0);

        // randomized traffic with frequent pc repeats, gaps, clears and resets
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 3) == 0) ? 32'h80 + 32'(4 * $urandom_range(0, 3)) : 32'h80;
            if ($urandom_range(0, 1) == 0) p = 32'h1000 + 32'(i * 4);
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0), p,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        #3;
        checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
